// File: rtl/priority_index_fifo.sv
`default_nettype none
// ============================================================================
// Module      : priority_index_fifo
// Description : Converts one-hot MSB/LSB outputs of a priority encoder into
//               binary indices plus span (left - right) and buffers the
//               results in a small show-ahead FIFO with valid/ready output.
//               Upstream has no backpressure: results arriving at a full
//               FIFO (with no pop in the same cycle) are dropped and counted.
// Ports       : clk_i, srst_i (sync, active-high)
//               data_left_i/data_right_i/data_val_i  - encoder results in
//               idx_left_o/idx_right_o/span_o/zero_o - FIFO head fields
//               data_val_o/data_ready_i              - output handshake
//               drop_cnt_o (saturating), overflow_o (sticky)
//               onehot_err_o                         - optional, see below
// Options     : `define PRIORITY_INDEX_ONEHOT_CHECK_EN adds onehot_err_o and
//               stores a per-entry "illegal input" flag.
// Revision    : 1.0 - initial release
// ============================================================================
module priority_index_fifo #(
   parameter int WIDTH      = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 8,
   localparam int c_ptr_w   = $clog2(WIDTH)
) (
   input  logic               clk_i,
   input  logic               srst_i,
   input  logic [WIDTH-1:0]   data_left_i,
   input  logic [WIDTH-1:0]   data_right_i,
   input  logic               data_val_i,
   output logic [c_ptr_w-1:0] idx_left_o,
   output logic [c_ptr_w-1:0] idx_right_o,
   output logic [c_ptr_w-1:0] span_o,
   output logic               zero_o,
`ifdef PRIORITY_INDEX_ONEHOT_CHECK_EN
   output logic               onehot_err_o,
`endif
   output logic               data_val_o,
   input  logic               data_ready_i,
   output logic [CNT_W-1:0]   drop_cnt_o,
   output logic               overflow_o
);

   localparam int c_ptr_d = $clog2(FIFO_DEPTH);
   localparam int c_occ_w = c_ptr_d + 1;

   typedef struct packed {
      logic [c_ptr_w-1:0] idx_l;
      logic [c_ptr_w-1:0] idx_r;
      logic [c_ptr_w-1:0] span;
      logic               zero;
`ifdef PRIORITY_INDEX_ONEHOT_CHECK_EN
      logic               err;
`endif
   } entry_t;

   // OR of the indices of all set bits; exact index for one-hot input.
   function automatic logic [c_ptr_w-1:0] f_encode(input logic [WIDTH-1:0] v);
      logic [c_ptr_w-1:0] idx;
      idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) idx = idx | c_ptr_w'(i);
      end
      return idx;
   endfunction

   // ------------------------------------------------------------------------
   // Stage 1: encode
   // ------------------------------------------------------------------------
   entry_t w_s1_next;
   entry_t r_s1;
   logic   r_s1_val;

   always_comb begin
      w_s1_next       = '0;
      w_s1_next.idx_l = f_encode(data_left_i);
      w_s1_next.idx_r = f_encode(data_right_i);
      w_s1_next.span  = w_s1_next.idx_l - w_s1_next.idx_r;
      w_s1_next.zero  = (data_left_i == '0) && (data_right_i == '0);
`ifdef PRIORITY_INDEX_ONEHOT_CHECK_EN
      // Multi-hot on either side, only one side zero, or inverted order.
      w_s1_next.err   = ((data_left_i  & (data_left_i  - 1'b1)) != '0) ||
                        ((data_right_i & (data_right_i - 1'b1)) != '0) ||
                        ((data_left_i == '0) != (data_right_i == '0))  ||
                        (w_s1_next.idx_l < w_s1_next.idx_r);
`endif
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         r_s1_val <= 1'b0;
         r_s1     <= '0;
      end else begin
         r_s1_val <= data_val_i;
         if (data_val_i) r_s1 <= w_s1_next;
      end
   end

   // ------------------------------------------------------------------------
   // Stage 2: result FIFO
   // ------------------------------------------------------------------------
   entry_t             r_mem [FIFO_DEPTH];
   logic [c_ptr_d-1:0] r_wr_ptr;
   logic [c_ptr_d-1:0] r_rd_ptr;
   logic [c_occ_w-1:0] r_count;
   logic [CNT_W-1:0]   r_drop_cnt;
   logic               r_overflow;

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push;
   logic w_drop;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == c_occ_w'(FIFO_DEPTH));
   assign w_pop   = !w_empty && data_ready_i;
   // A pop on the same edge frees a slot, so a full FIFO still accepts.
   assign w_push  = r_s1_val && (!w_full || w_pop);
   assign w_drop  = r_s1_val && w_full && !w_pop;

   // Storage needs no reset: the head is masked whenever the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= r_s1;
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_drop_cnt <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs: show-ahead head, zeroed while empty
   // ------------------------------------------------------------------------
   entry_t w_head;

   assign w_head       = w_empty ? '0 : r_mem[r_rd_ptr];
   assign data_val_o   = !w_empty;
   assign idx_left_o   = w_head.idx_l;
   assign idx_right_o  = w_head.idx_r;
   assign span_o       = w_head.span;
   assign zero_o       = w_head.zero;
`ifdef PRIORITY_INDEX_ONEHOT_CHECK_EN
   assign onehot_err_o = w_head.err;
`endif
   assign drop_cnt_o   = r_drop_cnt;
   assign overflow_o   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_priority_index_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_priority_index_fifo
// Description : Self-checking bench for priority_index_fifo. A queue-based
//               reference model predicts the FIFO head, drop counter and
//               overflow flag every cycle; a vector table and hand-written
//               sequences cover the documented corner cases. A second
//               instance with CNT_W=2 shares the stimulus to observe counter
//               saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_index_fifo;

   localparam int WIDTH = 16;
   localparam int DEPTH = 4;
   localparam int PW    = 4;

   logic             clk_i = 1'b0;
   logic             srst_i;
   logic [WIDTH-1:0] data_left_i;
   logic [WIDTH-1:0] data_right_i;
   logic             data_val_i;
   logic             data_ready_i;

   logic [PW-1:0] idx_left_o, idx_right_o, span_o;
   logic          zero_o, data_val_o, overflow_o;
   logic [7:0]    drop_cnt_o;
   logic          onehot_err_o;

   logic [PW-1:0] idx_left2, idx_right2, span2;
   logic          zero2, val2, overflow2;
   logic [1:0]    drop_cnt2;
   logic          err2;

   always #5 clk_i = ~clk_i;

   priority_index_fifo #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .CNT_W(8)) dut (
      .clk_i(clk_i), .srst_i(srst_i),
      .data_left_i(data_left_i), .data_right_i(data_right_i), .data_val_i(data_val_i),
      .idx_left_o(idx_left_o), .idx_right_o(idx_right_o), .span_o(span_o), .zero_o(zero_o),
`ifdef PRIORITY_INDEX_ONEHOT_CHECK_EN
      .onehot_err_o(onehot_err_o),
`endif
      .data_val_o(data_val_o), .data_ready_i(data_ready_i),
      .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o)
   );

   priority_index_fifo #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .CNT_W(2)) dut2 (
      .clk_i(clk_i), .srst_i(srst_i),
      .data_left_i(data_left_i), .data_right_i(data_right_i), .data_val_i(data_val_i),
      .idx_left_o(idx_left2), .idx_right_o(idx_right2), .span_o(span2), .zero_o(zero2),
`ifdef PRIORITY_INDEX_ONEHOT_CHECK_EN
      .onehot_err_o(err2),
`endif
      .data_val_o(val2), .data_ready_i(data_ready_i),
      .drop_cnt_o(drop_cnt2), .overflow_o(overflow2)
   );

`ifndef PRIORITY_INDEX_ONEHOT_CHECK_EN
   assign onehot_err_o = 1'b0;
   assign err2         = 1'b0;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------------
   typedef struct packed {
      logic [PW-1:0] l;
      logic [PW-1:0] r;
      logic [PW-1:0] s;
      logic          z;
      logic          e;
   } res_t;

   res_t q[$];
   res_t m_s1;
   bit   m_s1v  = 0;
   int   m_drop = 0;
   int   m_drop2 = 0;
   bit   m_ovf  = 0;

   function automatic res_t model_encode(input logic [WIDTH-1:0] left, input logic [WIDTH-1:0] right);
      res_t r;
      int   li = 0, ri = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (left[i])  li = li | i;
         if (right[i]) ri = ri | i;
      end
      r.l = PW'(li);
      r.r = PW'(ri);
      r.s = PW'((li - ri + 16) % 16);
      r.z = (left == 0) && (right == 0);
      r.e = ($countones(left) > 1) || ($countones(right) > 1) ||
            ((left == 0) != (right == 0)) || (li < ri);
      return r;
   endfunction

   task automatic model_edge();
      int pre;
      bit pop;
      if (srst_i) begin
         q.delete();
         m_s1v = 0; m_drop = 0; m_drop2 = 0; m_ovf = 0;
         return;
      end
      pre = q.size();
      pop = (pre != 0) && data_ready_i;
      if (pop) void'(q.pop_front());
      if (m_s1v) begin
         if (pre < DEPTH || pop) q.push_back(m_s1);
         else begin
            if (m_drop < 255) m_drop++;
            if (m_drop2 < 3) m_drop2++;
            m_ovf = 1;
         end
      end
      m_s1v = data_val_i;
      if (data_val_i) m_s1 = model_encode(data_left_i, data_right_i);
   endtask

   task automatic check_all();
      res_t h;
      bit   v;
      v = (q.size() != 0);
      h = v ? q[0] : '0;
      chk("val_o",     data_val_o,  v);
      chk("idx_left",  idx_left_o,  h.l);
      chk("idx_right", idx_right_o, h.r);
      chk("span",      span_o,      h.s);
      chk("zero",      zero_o,      h.z);
`ifdef PRIORITY_INDEX_ONEHOT_CHECK_EN
      chk("onehot_err", onehot_err_o, h.e);
`endif
      chk("drop_cnt",  drop_cnt_o,  m_drop);
      chk("overflow",  overflow_o,  m_ovf);
      chk("drop_cnt2", drop_cnt2,   m_drop2);
      chk("overflow2", overflow2,   m_ovf);
      chk("val_o2",    val2,        v);
      chk("idx_left2", idx_left2,   h.l);
   endtask

   // One clock: model advances on the edge, outputs compared 1 time unit later.
   task automatic step();
      @(posedge clk_i);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic drive(input logic val, input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
      data_val_i   = val;
      data_left_i  = l;
      data_right_i = r;
   endtask

   // ------------------------------------------------------------------------
   // Directed vectors
   // ------------------------------------------------------------------------
   typedef struct {
      logic [WIDTH-1:0] left;
      logic [WIDTH-1:0] right;
      logic [PW-1:0]    el;
      logic [PW-1:0]    er;
      logic [PW-1:0]    es;
      logic             ez;
      logic             ee;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vecs[0] = '{16'h0100, 16'h0004,  8,  2,  6, 0, 0};
      vecs[1] = '{16'h0000, 16'h0000,  0,  0,  0, 1, 0};
      vecs[2] = '{16'h8000, 16'h0001, 15,  0, 15, 0, 0};
      vecs[3] = '{16'h0001, 16'h0001,  0,  0,  0, 0, 0};
      vecs[4] = '{16'h0003, 16'h0001,  1,  0,  1, 0, 1};
      vecs[5] = '{16'h0002, 16'h0008,  1,  3, 14, 0, 1};
      vecs[6] = '{16'h0000, 16'h0010,  0,  4, 12, 0, 1};
      vecs[7] = '{16'h4000, 16'h4000, 14, 14,  0, 0, 0};

      srst_i = 1'b1;
      data_ready_i = 1'b1;
      drive(0, '0, '0);
      step();
      step();
      srst_i = 1'b0;
      chk("reset_val_o", data_val_o, 0);
      chk("reset_drop",  drop_cnt_o, 0);
      chk("reset_ovf",   overflow_o, 0);

      // Single results with fixed N+2 latency and N+3 fall.
      for (int i = 0; i < 8; i++) begin
         drive(1, vecs[i].left, vecs[i].right);
         step();
         drive(0, '0, '0);
         step();
         chk("vec_val",   data_val_o,  1);
         chk("vec_idx_l", idx_left_o,  vecs[i].el);
         chk("vec_idx_r", idx_right_o, vecs[i].er);
         chk("vec_span",  span_o,      vecs[i].es);
         chk("vec_zero",  zero_o,      vecs[i].ez);
`ifdef PRIORITY_INDEX_ONEHOT_CHECK_EN
         chk("vec_err",   onehot_err_o, vecs[i].ee);
`endif
         step();
         chk("vec_val_fall", data_val_o, 0);
      end

      // Six inputs into a stalled FIFO: four kept, two dropped.
      data_ready_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive(1, WIDTH'(1) << (i + 8), WIDTH'(1) << i);
         step();
      end
      drive(0, '0, '0);
      step();
      step();
      chk("ovf_drop_cnt", drop_cnt_o, 2);
      chk("ovf_flag",     overflow_o, 1);
      chk("ovf_head_l",   idx_left_o, 8);
      data_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_order", idx_right_o, i);
         step();
      end
      chk("drain_empty", data_val_o, 0);

      // Five more drops: the 2-bit counter must stop at 3.
      data_ready_i = 1'b0;
      for (int i = 0; i < 9; i++) begin
         drive(1, 16'h0020, 16'h0002);
         step();
      end
      drive(0, '0, '0);
      step();
      step();
      chk("sat_drop2", drop_cnt2,  3);
      chk("sat_drop",  drop_cnt_o, 7);

      // Full FIFO, ready high, input every cycle: no further drops.
      data_ready_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(1, WIDTH'(1) << (i % 16), 16'h0001);
         step();
         chk("full_tput_val", data_val_o, 1);
      end
      drive(0, '0, '0);
      chk("full_tput_drop", drop_cnt_o, 7);
      for (int i = 0; i < 8; i++) step();

      // Reset with the FIFO half full.
      data_ready_i = 1'b0;
      drive(1, 16'h0040, 16'h0004);
      step();
      step();
      drive(0, '0, '0);
      step();
      step();
      chk("half_full_val", data_val_o, 1);
      srst_i = 1'b1;
      step();
      srst_i = 1'b0;
      chk("rst_mid_val",  data_val_o,  0);
      chk("rst_mid_idx",  idx_left_o,  0);
      chk("rst_mid_drop", drop_cnt_o,  0);
      chk("rst_mid_ovf",  overflow_o,  0);
      data_ready_i = 1'b1;
      drive(1, 16'h0200, 16'h0008);
      step();
      drive(0, '0, '0);
      step();
      chk("post_rst_val", data_val_o, 1);
      chk("post_rst_l",   idx_left_o, 9);
      chk("post_rst_s",   span_o,     6);
      step();

      // Randomized traffic against the model.
      for (int c = 0; c < 600; c++) begin
         int mode, a, b;
         logic [WIDTH-1:0] l, r;
         mode = $urandom_range(0, 9);
         a = $urandom_range(0, WIDTH - 1);
         b = $urandom_range(0, a);
         l = WIDTH'(1) << a;
         r = WIDTH'(1) << b;
         if (mode == 0) begin l = '0; r = '0; end
         else if (mode == 1) begin l = WIDTH'($urandom); r = WIDTH'($urandom); end
         drive(logic'($urandom_range(0, 3) != 0), l, r);
         data_ready_i = ($urandom_range(0, 2) != 0);
         srst_i = ($urandom_range(0, 199) == 0);
         step();
      end
      srst_i = 1'b0;
      drive(0, '0, '0);
      data_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) step();
      chk("final_empty", data_val_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
